// File: rtl/axi_write_arbiter_pkg.sv
// Shared types and route encodings for the AXI write-path arbiter.
// The state encoding doubles as the WRITE_STATE output code.
package axi_wr_arb_pkg;

  typedef enum logic [1:0] {
    IDLE = 2'b00,
    ADDR = 2'b01,
    DATA = 2'b10,
    RESP = 2'b11
  } wr_state_e;

  localparam logic [3:0] ROUTE_IDLE  = 4'b0000;
  localparam logic [3:0] ROUTE_M0_S0 = 4'b0001;
  localparam logic [3:0] ROUTE_M0_S1 = 4'b0010;
  localparam logic [3:0] ROUTE_M0_DS = 4'b0011;
  localparam logic [3:0] ROUTE_M1_S0 = 4'b1001;
  localparam logic [3:0] ROUTE_M1_S1 = 4'b1010;
  localparam logic [3:0] ROUTE_M1_DS = 4'b1011;

  // Slave indices into the per-slave ready/valid vectors
  localparam logic [1:0] SLV_S0 = 2'd0;
  localparam logic [1:0] SLV_S1 = 2'd1;
  localparam logic [1:0] SLV_DS = 2'd2;

  function automatic logic [3:0] make_route(input logic m1, input logic [1:0] slv);
    logic [3:0] r;
    case ({m1, slv})
      {1'b0, SLV_S0}: r = ROUTE_M0_S0;
      {1'b0, SLV_S1}: r = ROUTE_M0_S1;
      {1'b0, SLV_DS}: r = ROUTE_M0_DS;
      {1'b1, SLV_S0}: r = ROUTE_M1_S0;
      {1'b1, SLV_S1}: r = ROUTE_M1_S1;
      {1'b1, SLV_DS}: r = ROUTE_M1_DS;
      default:        r = ROUTE_IDLE;
    endcase
    return r;
  endfunction

endpackage

// File: rtl/axi_write_arbiter_if.sv
// Write-path handshake bundle between the interconnect fabric and the arbiter.
// master: fabric side driving requests; slave: the arbiter consuming them.
interface axi_write_arbiter_if #(parameter int ADDR_W = 32);
  logic [1:0]        awvalid_m;
  logic [ADDR_W-1:0] awaddr_m0;
  logic [ADDR_W-1:0] awaddr_m1;
  logic [1:0]        wvalid_m;
  logic [1:0]        wlast_m;
  logic [1:0]        bready_m;
  logic [2:0]        awready_s;
  logic [2:0]        wready_s;
  logic [2:0]        bvalid_s;
  logic [1:0]        write_state;
  logic [3:0]        write_route;
  logic [1:0]        awgrant_m;
  logic              wr_timeout;

  modport master (
    output awvalid_m, awaddr_m0, awaddr_m1, wvalid_m, wlast_m, bready_m,
    output awready_s, wready_s, bvalid_s,
    input  write_state, write_route, awgrant_m, wr_timeout
  );

  modport slave (
    input  awvalid_m, awaddr_m0, awaddr_m1, wvalid_m, wlast_m, bready_m,
    input  awready_s, wready_s, bvalid_s,
    output write_state, write_route, awgrant_m, wr_timeout
  );
endinterface

// File: rtl/axi_write_arbiter_rr_arbiter_2.sv
// Two-request round-robin: combinational grant, pointer registered.
// ptr_q=0 favours M0; on advance the pointer moves away from the last winner.
module rr_arbiter_2 (
  input  logic       clk,
  input  logic       rst,
  input  logic [1:0] req,
  input  logic       advance,
  input  logic       last_winner,
  output logic [1:0] grant
);

  logic ptr_q;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) ptr_q <= 1'b0;
    else if (advance) ptr_q <= ~last_winner;
  end

  always_comb begin
    grant = 2'b00;
    if (!ptr_q) begin
      if (req[0])      grant = 2'b01;
      else if (req[1]) grant = 2'b10;
    end else begin
      if (req[1])      grant = 2'b10;
      else if (req[0]) grant = 2'b01;
    end
  end

endmodule

// File: rtl/axi_write_arbiter.sv
// AXI write-path arbiter for 2 masters / 3 slave targets (S0, S1, default).
// Optional watchdog built when WRITE_TIMEOUT_EN is defined.
//
// state | meaning
// IDLE  | no transaction; arbitrate any AW request
// ADDR  | grant held, waiting for AW handshake; early W beats tracked
// DATA  | AW done, waiting for the WLAST handshake
// RESP  | all data sent, waiting for the B handshake
module axi_write_arbiter
  import axi_wr_arb_pkg::*;
#(
  parameter int                ADDR_W      = 32,
  parameter logic [ADDR_W-1:0] S0_BASE     = 32'h0000_0000,
  parameter logic [ADDR_W-1:0] S1_BASE     = 32'h0001_0000,
  parameter logic [ADDR_W-1:0] REGION_MASK = 32'hFFFF_0000
`ifdef WRITE_TIMEOUT_EN
  , parameter int              TIMEOUT_CYC = 256
`endif
) (
  input  logic ACLK,
  input  logic ARESET,
  axi_write_arbiter_if.slave bus
);

  wr_state_e         state_q, state_d;
  logic [1:0]        grant_q, grant_d;
  logic [3:0]        route_q, route_d;
  logic [1:0]        sel_q, sel_d;
  logic              wlast_q, wlast_d;
  logic [1:0]        arb_grant;
  logic              ptr_adv;
  logic              g_idx;
  logic [ADDR_W-1:0] win_addr;
  logic [1:0]        win_slv;
  logic              aw_hs, w_last_hs, b_hs;
  logic              wd_expire;

  assign g_idx     = grant_q[1];
  assign aw_hs     = bus.awvalid_m[g_idx] & bus.awready_s[sel_q];
  assign w_last_hs = bus.wvalid_m[g_idx] & bus.wready_s[sel_q] & bus.wlast_m[g_idx];
  assign b_hs      = bus.bvalid_s[sel_q] & bus.bready_m[g_idx];

  rr_arbiter_2 u_rr (
    .clk         (ACLK),
    .rst         (ARESET),
    .req         (bus.awvalid_m),
    .advance     (ptr_adv),
    .last_winner (g_idx),
    .grant       (arb_grant)
  );

  always_comb begin
    win_addr = arb_grant[1] ? bus.awaddr_m1 : bus.awaddr_m0;
    if ((win_addr & REGION_MASK) == S0_BASE)      win_slv = SLV_S0;
    else if ((win_addr & REGION_MASK) == S1_BASE) win_slv = SLV_S1;
    else                                          win_slv = SLV_DS;
  end

  always_ff @(posedge ACLK or posedge ARESET) begin
    if (ARESET) begin
      state_q <= IDLE;
      grant_q <= 2'b00;
      route_q <= ROUTE_IDLE;
      sel_q   <= SLV_S0;
      wlast_q <= 1'b0;
    end else begin
      state_q <= state_d;
      grant_q <= grant_d;
      route_q <= route_d;
      sel_q   <= sel_d;
      wlast_q <= wlast_d;
    end
  end

  always_comb begin
    state_d = state_q;
    case (state_q)
      IDLE:    if (|bus.awvalid_m) state_d = ADDR;
      ADDR:    if (aw_hs) state_d = (wlast_q | w_last_hs) ? RESP : DATA;
      DATA:    if (w_last_hs) state_d = RESP;
      RESP:    if (b_hs) state_d = IDLE;
      default: state_d = IDLE;
    endcase
    if (wd_expire) state_d = IDLE;
  end

  always_comb begin
    grant_d = grant_q;
    route_d = route_q;
    sel_d   = sel_q;
    wlast_d = wlast_q;
    ptr_adv = 1'b0;
    if (state_q == IDLE && |bus.awvalid_m) begin
      grant_d = arb_grant;
      sel_d   = win_slv;
      route_d = make_route(arb_grant[1], win_slv);
    end
    if (state_q == ADDR && w_last_hs) wlast_d = 1'b1;
    // Completion or abort: release the grant and rotate priority
    if (state_q != IDLE && state_d == IDLE) begin
      grant_d = 2'b00;
      route_d = ROUTE_IDLE;
      wlast_d = 1'b0;
      ptr_adv = 1'b1;
    end
  end

  assign bus.write_state = state_q;
  assign bus.write_route = route_q;
  assign bus.awgrant_m   = grant_q;

`ifdef WRITE_TIMEOUT_EN
  logic [15:0] wd_cnt_q;
  logic        tmo_q;

  // Down-counter reloaded on every state change; terminal count aborts
  always_ff @(posedge ACLK or posedge ARESET) begin
    if (ARESET) begin
      wd_cnt_q <= 16'(TIMEOUT_CYC - 1);
      tmo_q    <= 1'b0;
    end else begin
      tmo_q <= wd_expire;
      if (state_d != state_q)
        wd_cnt_q <= 16'(TIMEOUT_CYC - 1);
      else if ((state_q == DATA || state_q == RESP) && wd_cnt_q != 16'd0)
        wd_cnt_q <= wd_cnt_q - 16'd1;
    end
  end

  assign wd_expire      = (state_q == DATA || state_q == RESP) && (wd_cnt_q == 16'd0);
  assign bus.wr_timeout = tmo_q;
`else
  assign wd_expire      = 1'b0;
  assign bus.wr_timeout = 1'b0;
`endif

endmodule
